spi_resp16: RTL and testbench
=============================

// Module: spi_resp16
// PURPOSE
//  SPI responder (slave) for the 16-bit SPI master links: mode 0, MSB first.
//  Samples MOSI on SCLK rise, drives MISO on SCLK fall. One 16-bit word each
//  way per SS_n-low frame. SS_n, SCLK and MOSI are asynchronous to clk; the
//  block synchronizes them and acts on detected edges. Used as a bench
//  responder and in FPGA-side peripheral emulation.
// PARAMETERS
//  DATA_W       16  bits per frame
//  SYNC_STAGES  2   synchronizer flops on SS_n/SCLK/MOSI (min 2)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous, active-high reset
//  SS_n       in   1       slave select from master, active low
//  SCLK       in   1       serial clock from master, idles high
//  MOSI       in   1       serial data from master
//  MISO       out  1       serial data to master
//  wrt        in   1       pulse: tx_buf <= tx_data
//  tx_data    in   DATA_W  word to return in the next frame
//  clr_rdy    in   1       clears rdy
//  rx_data    out  DATA_W  last good word received
//  rdy        out  1       sticky: good frame completed
//  frame_err  out  1       1-clk pulse: frame ended with bit count != DATA_W
// BEHAVIOUR
//  Reset: all regs 0 except SS_n/SCLK synchronizers preset to 1;
//   MISO=0, rx_data=0, rdy=0, frame_err=0, state=IDLE.
//  Sync: rise/fall of SS_n/SCLK detected from last two sync stages;
//   action lands SYNC_STAGES+1 clks after pin edge. MOSI uses the same depth,
//   so its sample aligns with the SCLK edge it is taken on.
//  tx_buf: written on wrt in any state; a write during a frame affects only
//   the next frame.
//  FSM IDLE: on SS_n fall -> SHIFT; tx_shft <= tx_buf, bit_cnt <= 0,
//   rx_shft <= 0.
//  FSM SHIFT:
//   - SCLK rise: rx_shft <= {rx_shft[DATA_W-2:0], MOSI_sync}.
//     bit_cnt++, saturating at DATA_W+1.
//   - SCLK fall with 0 < bit_cnt < DATA_W: tx_shft <<= 1 (LSB fill 0).
//   - SCLK falls with bit_cnt == 0 are ignored (master front-porch fall).
//   - SS_n rise -> IDLE. If bit_cnt == DATA_W: rx_data <= rx_shft, rdy <= 1.
//     Otherwise frame_err pulses and rx_data/rdy are unchanged.
//   - SS_n rise detected in the same clk as an SCLK edge: SS_n wins;
//     the SCLK edge is discarded.
//  MISO = tx_shft[DATA_W-1] registered. Valid SYNC_STAGES+2 clks after SS_n
//   fall; updates after each counted SCLK fall. Holds its value in IDLE.
//  rdy: set on good frame end; cleared by clr_rdy; set wins if simultaneous.
//  Reset mid-frame: returns to IDLE immediately. The next SS_n fall starts
//   a fresh frame; no partial word is reported.
//  Timing: requires SCLK half-period >= SYNC_STAGES+3 clks (master: 16 clks).
// TESTING
//  1. wrt tx_data=16'hA5C3; master sends 16'h1234 -> MISO stream A5C3
//     MSB-first, rx_data=16'h1234, rdy=1, frame_err=0.
//  2. Back-to-back frames 16'hFFFF then 16'h0001 with no clr_rdy ->
//     rx_data=16'h0001, rdy remains 1. clr_rdy -> rdy=0 next clk.
//  3. SS_n raised after 9 SCLK rises -> frame_err 1-clk pulse;
//     rx_data and rdy unchanged.
//  4. 17 SCLK rises before SS_n rise -> frame_err pulse, rx_data unchanged.
//  5. wrt tx_data=16'h0F0F mid-frame while tx_buf=16'h8001 -> current frame
//     returns 8001, next frame returns 0F0F.
//  6. rst asserted after 8 bits -> outputs 0 async. The following full
//     frame 16'hBEEF -> rx_data=16'hBEEF, rdy=1.

Source files
------------

// File: rtl/spi_resp16_if.sv
// spi_resp16_if: bundles the SPI pin side and the host register side of the
// 16-bit SPI responder.
//   Pin side   : SS_n, SCLK, MOSI (master -> responder), MISO (responder -> master)
//   Host side  : wrt, tx_data, clr_rdy (host -> responder),
//                rx_data, rdy, frame_err (responder -> host)
// The slave modport is the responder's view; the master modport is the view
// of whatever drives the link and the host register side (e.g. a bench).
interface spi_resp16_if #(
  parameter int DATA_W = 16
);
  logic              SS_n;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;
  logic              wrt;
  logic [DATA_W-1:0] tx_data;
  logic              clr_rdy;
  logic [DATA_W-1:0] rx_data;
  logic              rdy;
  logic              frame_err;

  modport slave (
    input  SS_n, SCLK, MOSI, wrt, tx_data, clr_rdy,
    output MISO, rx_data, rdy, frame_err
  );

  modport master (
    output SS_n, SCLK, MOSI, wrt, tx_data, clr_rdy,
    input  MISO, rx_data, rdy, frame_err
  );
endinterface

// File: rtl/spi_resp16.sv
// spi_resp16: SPI responder, mode 0, MSB first, one DATA_W-bit word each way
// per SS_n-low frame. SS_n/SCLK/MOSI are asynchronous and are synchronized
// into clk; all actions are taken on detected edges.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - spi_resp16_if.slave:
//          SS_n, SCLK, MOSI in; MISO out (pin side)
//          wrt, tx_data, clr_rdy in; rx_data, rdy, frame_err out (host side)
// Parameters:
//   DATA_W      - bits per frame
//   SYNC_STAGES - synchronizer depth on SS_n/SCLK/MOSI (>= 2)
module spi_resp16 #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_resp16_if.slave    bus
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // SS_n/SCLK carry one extra flop beyond the synchronizer so the edge is
  // seen between the last synchronizer stage and its delayed copy.
  logic [SYNC_STAGES:0]   ss_sync;
  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic ss_fall, ss_rise, sclk_fall, sclk_rise, mosi_bit;

  state_t            state, state_nx;
  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] tx_shft, tx_shft_nx;
  logic [DATA_W-1:0] rx_shft, rx_shft_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [DATA_W-1:0] rx_data, rx_data_nx;
  logic              rdy, rdy_nx;
  logic              frame_err, frame_err_nx;
  logic              miso;

  // Synchronizers: SS_n/SCLK preset high (their idle level) so reset never
  // fabricates an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-1:0], bus.SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], bus.SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
    end
  end

  assign ss_fall   =  ss_sync[SYNC_STAGES]   & ~ss_sync[SYNC_STAGES-1];
  assign ss_rise   = ~ss_sync[SYNC_STAGES]   &  ss_sync[SYNC_STAGES-1];
  assign sclk_fall =  sclk_sync[SYNC_STAGES] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_sync[SYNC_STAGES] &  sclk_sync[SYNC_STAGES-1];
  // MOSI taken at the stage where the new SCLK level first appears, so the
  // sample lines up with the rising edge it belongs to.
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

  // Transmit buffer: a write during a frame is picked up by the next frame
  // because tx_shft is only loaded on SS_n fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf <= '0;
    end else if (bus.wrt) begin
      tx_buf <= bus.tx_data;
    end
  end

  always_comb begin
    state_nx     = state;
    tx_shft_nx   = tx_shft;
    rx_shft_nx   = rx_shft;
    bit_cnt_nx   = bit_cnt;
    rx_data_nx   = rx_data;
    // Clear first so a good-frame set below overrides a simultaneous clr_rdy.
    rdy_nx       = rdy & ~bus.clr_rdy;
    frame_err_nx = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx   = SHIFT;
          tx_shft_nx = tx_buf;
          bit_cnt_nx = '0;
          rx_shft_nx = '0;
        end
      end
      SHIFT: begin
        // SS_n rise takes priority; any SCLK edge in the same clk is dropped.
        if (ss_rise) begin
          state_nx = IDLE;
          if (bit_cnt == CNT_FULL) begin
            rx_data_nx = rx_shft;
            rdy_nx     = 1'b1;
          end else begin
            frame_err_nx = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_shft_nx = {rx_shft[DATA_W-2:0], mosi_bit};
          if (bit_cnt != CNT_MAX) begin
            bit_cnt_nx = bit_cnt + CNT_W'(1);
          end
        end else if (sclk_fall && (bit_cnt != '0) && (bit_cnt < CNT_FULL)) begin
          // bit_cnt == 0 is the master's front-porch fall: MSB already on MISO.
          tx_shft_nx = {tx_shft[DATA_W-2:0], 1'b0};
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_shft   <= '0;
      rx_shft   <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
    end else begin
      state     <= state_nx;
      tx_shft   <= tx_shft_nx;
      rx_shft   <= rx_shft_nx;
      bit_cnt   <= bit_cnt_nx;
      rx_data   <= rx_data_nx;
      rdy       <= rdy_nx;
      frame_err <= frame_err_nx;
      // Registered copy of the shifter MSB; holds in IDLE since tx_shft does.
      miso      <= tx_shft[DATA_W-1];
    end
  end

  assign bus.MISO      = miso;
  assign bus.rx_data   = rx_data;
  assign bus.rdy       = rdy;
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_spi_resp16.sv
// tb_spi_resp16: drives spi_resp16 as an SPI master (SCLK idles high, front
// porch fall, MOSI changed while SCLK low, MISO sampled just before each rise)
// and checks frame results against a queue of expected records.
`timescale 1ns/1ps
module tb_spi_resp16;

  localparam int HALF = 8;

  typedef struct {
    logic        pre_wrt;
    logic [15:0] pre_data;
    logic        mid_wrt;
    logic [15:0] mid_data;
    logic [15:0] mosi;
    int          nrises;
    logic        chk_miso;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic        exp_rdy;
    int          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  spi_resp16_if #(.DATA_W(16)) bus ();

  spi_resp16 #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nmis = 0;
  int   err_cnt = 0;
  int   err_run = 0;
  int   err_max_run = 0;
  int   rdy_hi = 0;
  vec_t sb_q[$];
  vec_t vecs[8];

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_run = err_run + 1;
      if (err_run > err_max_run) err_max_run = err_run;
    end else begin
      err_run = 0;
    end
    if (bus.rdy === 1'b1) rdy_hi = rdy_hi + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nmis = nmis + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_wrt(input logic [15:0] d);
    bus.tx_data = d;
    bus.wrt     = 1'b1;
    @(negedge clk);
    bus.wrt     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t        e;
    logic [15:0] got;
    int          err0;
    sb_q.push_back(v);
    if (v.pre_wrt) pulse_wrt(v.pre_data);
    err0 = err_cnt;
    got  = '0;
    bus.SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.SCLK = 1'b0;
    for (int i = 0; i < v.nrises; i++) begin
      bus.MOSI = (i < 16) ? v.mosi[15-i] : 1'b0;
      if (v.mid_wrt && i == 8) pulse_wrt(v.mid_data);
      repeat (HALF) @(negedge clk);
      if (i < 16) got = {got[14:0], bus.MISO};
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i != v.nrises - 1) bus.SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.SS_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    e = sb_q.pop_front();
    if (e.chk_miso) check("miso_stream", 32'(got), 32'(e.exp_miso));
    check("rx_data", 32'(bus.rx_data), 32'(e.exp_rx));
    check("rdy", 32'(bus.rdy), 32'(e.exp_rdy));
    check("frame_err_pulses", 32'(err_cnt - err0), 32'(e.exp_err));
  endtask

  initial begin
    vec_t hv;
    int   rdy0;

    //            pre_wrt pre_data mid_wrt mid_data mosi    n   chk   exp_miso exp_rx   rdy  err
    vecs[0] = '{1'b1, 16'hA5C3, 1'b0, 16'h0000, 16'h1234, 16, 1'b1, 16'hA5C3, 16'h1234, 1'b1, 0};
    vecs[1] = '{1'b1, 16'h5A5A, 1'b0, 16'h0000, 16'hFFFF, 16, 1'b1, 16'h5A5A, 16'hFFFF, 1'b1, 0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 16, 1'b1, 16'h5A5A, 16'h0001, 1'b1, 0};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'hABCD,  9, 1'b0, 16'h0000, 16'h0001, 1'b0, 1};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h7777, 17, 1'b1, 16'h5A5A, 16'h0001, 1'b0, 1};
    vecs[5] = '{1'b1, 16'h8001, 1'b0, 16'h0000, 16'hC0DE, 16, 1'b1, 16'h8001, 16'hC0DE, 1'b1, 0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 16'h0F0F, 16'h1111, 16, 1'b1, 16'h8001, 16'h1111, 1'b1, 0};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h2222, 16, 1'b1, 16'h0F0F, 16'h2222, 1'b1, 0};

    rst         = 1'b1;
    bus.SS_n    = 1'b1;
    bus.SCLK    = 1'b1;
    bus.MOSI    = 1'b0;
    bus.wrt     = 1'b0;
    bus.tx_data = '0;
    bus.clr_rdy = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_miso", 32'(bus.MISO), 32'h0);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_rdy", 32'(bus.rdy), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k]);
      if (k == 2) begin
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        check("clr_rdy", 32'(bus.rdy), 32'h0);
      end
    end

    // clr_rdy held through a good frame: the set must still show for one clk.
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    rdy0 = rdy_hi;
    hv = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3333, 16, 1'b1, 16'h0F0F, 16'h3333, 1'b0, 0};
    run_vec(hv);
    check("rdy_set_wins_clks", 32'(rdy_hi - rdy0), 32'd1);
    bus.clr_rdy = 1'b0;
    @(negedge clk);

    // Reset in the middle of a frame after 8 bits.
    bus.SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.SCLK = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.MOSI = i[0];
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i != 7) bus.SCLK = 1'b0;
    end
    check("pre_reset_miso", 32'(bus.MISO), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_miso", 32'(bus.MISO), 32'h0);
    check("async_reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("async_reset_rdy", 32'(bus.rdy), 32'h0);
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    hv = '{1'b1, 16'h1357, 1'b0, 16'h0000, 16'hBEEF, 16, 1'b1, 16'h1357, 16'hBEEF, 1'b1, 0};
    run_vec(hv);

    check("frame_err_total", 32'(err_cnt), 32'd2);
    check("frame_err_width", 32'(err_max_run), 32'd1);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
